fixed_inv_sqrt_arb: RTL and testbench

FIXED_INV_SQRT_ARB -- requirements
Module: fixed_inv_sqrt_arb

---
 rtl/fixed_pkg.sv | 30 +++
 rtl/fixed_inv_sqrt.sv | 49 ++++
 rtl/fixed_inv_sqrt_arb.sv | 102 ++++++++++
 tb/tb_fixed_inv_sqrt_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - Q16.15 fixed-point type, constants and Newton-Raphson helpers
`timescale 1ns/1ps
package fixed_pkg;
  localparam int D = 15;
  typedef logic signed [31:0] fixed_t;
  localparam fixed_t FIXED_1   = 32'sh8000;
  localparam fixed_t FIXED_1_5 = 32'shC000;

  function automatic logic [4:0] msb_index(input fixed_t x);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 31; i++) begin
      if (x[i]) p = 5'(i);
    end
    return p;
  endfunction

  // One refinement step y' = y * (1.5 - x*y*y/2), all products kept at 64 bits.
  function automatic fixed_t nr_step(input fixed_t x, input fixed_t y);
    logic signed [63:0] xw, yw, c15, yy, xyy, t, yn;
    xw  = {{32{x[31]}}, x};
    yw  = {{32{y[31]}}, y};
    c15 = {{32{FIXED_1_5[31]}}, FIXED_1_5};
    yy  = (yw * yw) >>> D;
    xyy = (xw * yy) >>> D;
    t   = c15 - (xyy >>> 1);
    yn  = (yw * t) >>> D;
    return yn[31:0];
  endfunction
endpackage

// File: rtl/fixed_inv_sqrt.sv
// rtl/fixed_inv_sqrt.sv - four-stage pipelined 1/sqrt(x): exponent seed plus three Newton steps
`timescale 1ns/1ps
module fixed_inv_sqrt
  import fixed_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [31:0]  x_in,
  output logic [31:0]  y_out
);
  fixed_t x0_q, x1_q, x2_q;
  fixed_t y0_q, y1_q, y2_q, y3_q;
  fixed_t y0_d;
  logic [4:0] p;
  int sh;

  // Seed is exact for powers of four; odd exponents start at 1.5x the lower bound.
  always_comb begin
    p    = msb_index(x_in);
    sh   = 0;
    y0_d = FIXED_1;
    if (!x_in[31] && x_in != '0) begin
      if (p[0]) begin
        sh   = (45 - int'(p)) / 2;
        y0_d = 32'sd1 <<< sh;
      end else begin
        sh   = (42 - int'(p)) / 2;
        y0_d = 32'sd3 <<< sh;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x0_q <= '0; x1_q <= '0; x2_q <= '0;
      y0_q <= '0; y1_q <= '0; y2_q <= '0; y3_q <= '0;
    end else begin
      x0_q <= x_in;
      y0_q <= y0_d;
      x1_q <= x0_q;
      y1_q <= nr_step(x0_q, y0_q);
      x2_q <= x1_q;
      y2_q <= nr_step(x1_q, y1_q);
      y3_q <= nr_step(x2_q, y2_q);
    end
  end

  assign y_out = y3_q;
endmodule

// File: rtl/fixed_inv_sqrt_arb.sv
// rtl/fixed_inv_sqrt_arb.sv - round-robin sharing of one fixed_inv_sqrt among N_REQ requesters
`timescale 1ns/1ps
module fixed_inv_sqrt_arb
  import fixed_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [N_REQ-1:0]     req_valid_in,
  input  logic [N_REQ*32-1:0]  req_data_in,
  output logic [N_REQ-1:0]     req_ready_out,
  output logic [N_REQ-1:0]     resp_valid_out,
  output logic [N_REQ*32-1:0]  resp_data_out,
  input  logic [N_REQ-1:0]     resp_ready_in,
  output logic                 busy_out
);
  localparam int LAT = 4;
  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = IW + 1;

  logic [N_REQ-1:0]          outstanding_q, outstanding_d;
  logic [N_REQ-1:0]          resp_valid_q, resp_valid_d;
  logic [N_REQ*32-1:0]       resp_data_q, resp_data_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]            tag_v_q;
  logic [LAT-1:0][IW-1:0]    tag_idx_q;

  logic [N_REQ-1:0] eligible, grant_oh, resp_hs;
  logic             grant_any;
  logic [IW-1:0]    grant_idx;
  logic [CW-1:0]    cand;
  fixed_t           unit_x, unit_y;

  assign eligible = req_valid_in & ~outstanding_q;
  assign resp_hs  = resp_valid_q & resp_ready_in;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!grant_any && eligible[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    // Ready must drop with reset even while requesters keep valid high.
    if (!rst_n_in) grant_any = 1'b0;
    grant_oh = grant_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  assign unit_x = grant_any ? req_data_in[32*grant_idx +: 32] : 32'sh0;

  fixed_inv_sqrt u_inv_sqrt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .x_in     (unit_x),
    .y_out    (unit_y)
  );

  // A slot is always empty when its result lands, so capture never collides with a hold.
  always_comb begin
    outstanding_d = (outstanding_q & ~resp_hs) | grant_oh;
    resp_valid_d  = resp_valid_q & ~resp_hs;
    resp_data_d   = resp_data_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (resp_hs[i]) resp_data_d[32*i +: 32] = '0;
    end
    if (tag_v_q[LAT-1]) begin
      resp_valid_d[tag_idx_q[LAT-1]]       = 1'b1;
      resp_data_d[32*tag_idx_q[LAT-1] +: 32] = unit_y;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      outstanding_q <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      rr_ptr_q      <= '0;
      tag_v_q       <= '0;
      tag_idx_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      rr_ptr_q      <= rr_ptr_d;
      tag_v_q       <= {tag_v_q[LAT-2:0], grant_any};
      tag_idx_q     <= {tag_idx_q[LAT-2:0], grant_idx};
    end
  end

  assign req_ready_out  = grant_oh;
  assign resp_valid_out = resp_valid_q;
  assign resp_data_out  = resp_data_q;
  assign busy_out       = |outstanding_q;
endmodule

// File: tb/tb_fixed_inv_sqrt_arb.sv
// tb/tb_fixed_inv_sqrt_arb.sv - directed self-checking bench for fixed_inv_sqrt_arb
`timescale 1ns/1ps
module tb_fixed_inv_sqrt_arb;
  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [3:0]   req_valid_in;
  logic [127:0] req_data_in;
  logic [3:0]   req_ready_out;
  logic [3:0]   resp_valid_out;
  logic [127:0] resp_data_out;
  logic [3:0]   resp_ready_in;
  logic         busy_out;

  int checks = 0;
  int errors = 0;

  fixed_inv_sqrt_arb #(.N_REQ(4)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .resp_valid_out (resp_valid_out),
    .resp_data_out  (resp_data_out),
    .resp_ready_in  (resp_ready_in),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst_n_in      = 1'b0;
    req_valid_in  = '0;
    req_data_in   = '0;
    resp_ready_in = '0;
    tick;
    tick;
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset;
    rst_n_in      = 1'b0;
    req_valid_in  = 4'hF;
    req_data_in   = {4{32'h0000_8000}};
    resp_ready_in = 4'hF;
    #1;
    checks++; if (req_ready_out !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", req_ready_out); end
    tick;
    checks++; if (resp_valid_out !== 4'h0) begin errors++; $display("FAIL reset_resp_valid: got %h expected 0", resp_valid_out); end
    checks++; if (resp_data_out !== 128'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    req_valid_in = '0;
    rst_n_in     = 1'b1;
  endtask

  task automatic test_single(input int idx, input logic [31:0] data, input logic [31:0] exp, input bit chk_data);
    logic [3:0] ev;
    logic [31:0] got;
    int diff;
    do_reset;
    req_data_in[32*idx +: 32] = data;
    req_valid_in[idx] = 1'b1;
    #1;
    ev = 4'(1 << idx);
    checks++; if (req_ready_out !== ev) begin errors++; $display("FAIL single_ready[%0d]: got %h expected %h", idx, req_ready_out, ev); end
    tick;
    req_valid_in = '0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick;
      #1;
      ev = (k == 5) ? 4'(1 << idx) : 4'h0;
      checks++; if (resp_valid_out !== ev) begin errors++; $display("FAIL single_latency[%0d] cycle t+%0d: got %h expected %h", idx, k, resp_valid_out, ev); end
    end
    got  = resp_data_out[32*idx +: 32];
    diff = $signed(got) - $signed(exp);
    if (chk_data) begin
      checks++; if (diff > 4 || diff < -4) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", idx, got, exp); end
    end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL single_busy[%0d]: got %b expected 1", idx, busy_out); end
    resp_ready_in[idx] = 1'b1;
    tick;
    resp_ready_in = '0;
    #1;
    checks++; if (resp_valid_out !== 4'h0 || busy_out !== 1'b0) begin errors++; $display("FAIL single_accept[%0d]: got valid %h busy %b expected 0 0", idx, resp_valid_out, busy_out); end
  endtask

  task automatic test_all4;
    logic [31:0] op [4];
    logic [31:0] res [4];
    logic [3:0] ev, er;
    logic [31:0] got;
    int diff;
    op[0] = 32'h0000_8000; res[0] = 32'h0000_8000;
    op[1] = 32'h0002_0000; res[1] = 32'h0000_4000;
    op[2] = 32'h0008_0000; res[2] = 32'h0000_2000;
    op[3] = 32'h0000_2000; res[3] = 32'h0001_0000;
    do_reset;
    for (int i = 0; i < 4; i++) req_data_in[32*i +: 32] = op[i];
    req_valid_in = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      er = (c < 4) ? 4'(1 << c) : 4'h0;
      ev = '0;
      for (int i = 0; i < 4; i++) if (c >= i + 5) ev[i] = 1'b1;
      checks++; if (req_ready_out !== er) begin errors++; $display("FAIL all4_grant cycle %0d: got %h expected %h", c, req_ready_out, er); end
      checks++; if (resp_valid_out !== ev) begin errors++; $display("FAIL all4_resp cycle %0d: got %h expected %h", c, resp_valid_out, ev); end
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      got  = resp_data_out[32*i +: 32];
      diff = $signed(got) - $signed(res[i]);
      checks++; if (diff > 4 || diff < -4) begin errors++; $display("FAIL all4_data[%0d]: got %h expected %h", i, got, res[i]); end
    end
    req_valid_in  = '0;
    resp_ready_in = 4'hF;
    tick;
    #1;
    checks++; if (resp_valid_out !== 4'h0 || busy_out !== 1'b0) begin errors++; $display("FAIL all4_drain: got valid %h busy %b expected 0 0", resp_valid_out, busy_out); end
  endtask

  task automatic test_backpressure;
    int g [4];
    bit stable_bad, onehot_bad;
    for (int i = 0; i < 4; i++) g[i] = 0;
    stable_bad = 1'b0;
    onehot_bad = 1'b0;
    do_reset;
    req_data_in   = {4{32'h0000_8000}};
    resp_ready_in = 4'b1101;
    req_valid_in  = 4'hF;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < 4; i++) if (req_ready_out[i]) g[i]++;
      if ($countones(req_ready_out) > 1) onehot_bad = 1'b1;
      if (c >= 6 && (resp_valid_out[1] !== 1'b1 || resp_data_out[63:32] !== 32'h0000_8000)) stable_bad = 1'b1;
      tick;
    end
    checks++; if (g[0] != 4) begin errors++; $display("FAIL bp_grants0: got %0d expected 4", g[0]); end
    checks++; if (g[1] != 1) begin errors++; $display("FAIL bp_grants1: got %0d expected 1", g[1]); end
    checks++; if (g[2] != 3) begin errors++; $display("FAIL bp_grants2: got %0d expected 3", g[2]); end
    checks++; if (g[3] != 3) begin errors++; $display("FAIL bp_grants3: got %0d expected 3", g[3]); end
    checks++; if (onehot_bad) begin errors++; $display("FAIL bp_onehot: got multi-bit grant expected one-hot"); end
    checks++; if (stable_bad) begin errors++; $display("FAIL bp_hold1: got unstable resp 1 expected held valid with 00008000"); end
    req_valid_in  = '0;
    resp_ready_in = 4'hF;
    tick;
    #1;
    checks++; if (resp_valid_out[1] !== 1'b0) begin errors++; $display("FAIL bp_release1: got %b expected 0", resp_valid_out[1]); end
  endtask

  task automatic test_reset_mid;
    bit bad;
    bad = 1'b0;
    do_reset;
    req_data_in  = {4{32'h0000_8000}};
    req_valid_in = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready_out !== 4'(1 << c)) begin errors++; $display("FAIL rmid_grant cycle %0d: got %h expected %h", c, req_ready_out, 4'(1 << c)); end
      tick;
    end
    req_valid_in = '0;
    tick;
    req_valid_in = 4'hF;
    rst_n_in     = 1'b0;
    #1;
    checks++; if (req_ready_out !== 4'h0 || busy_out !== 1'b0) begin errors++; $display("FAIL rmid_in_reset: got ready %h busy %b expected 0 0", req_ready_out, busy_out); end
    tick;
    req_valid_in = '0;
    rst_n_in     = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (resp_valid_out !== 4'h0 || busy_out !== 1'b0) bad = 1'b1;
      tick;
    end
    checks++; if (bad) begin errors++; $display("FAIL rmid_discard: got stale response or busy expected none"); end
    req_valid_in = 4'hF;
    #1;
    checks++; if (req_ready_out !== 4'b0001) begin errors++; $display("FAIL rmid_restart: got %h expected 1", req_ready_out); end
    tick;
    req_valid_in = '0;
  endtask

  task automatic test_same_cycle;
    logic [3:0] ev;
    logic [31:0] got;
    int diff;
    do_reset;
    req_data_in[127:96] = 32'h0000_8000;
    req_valid_in = 4'b1000;
    #1;
    checks++; if (req_ready_out !== 4'b1000) begin errors++; $display("FAIL same_grant0: got %h expected 8", req_ready_out); end
    for (int k = 1; k <= 5; k++) tick;
    #1;
    checks++; if (resp_valid_out !== 4'b1000 || resp_data_out[127:96] !== 32'h0000_8000) begin errors++; $display("FAIL same_first_resp: got %h %h expected 8 00008000", resp_valid_out, resp_data_out[127:96]); end
    req_data_in[127:96] = 32'h0002_0000;
    resp_ready_in[3]    = 1'b1;
    #1;
    checks++; if (req_ready_out !== 4'h0) begin errors++; $display("FAIL same_no_grant: got %h expected 0", req_ready_out); end
    tick;
    resp_ready_in = '0;
    #1;
    checks++; if (req_ready_out !== 4'b1000) begin errors++; $display("FAIL same_regrant: got %h expected 8", req_ready_out); end
    checks++; if (resp_valid_out !== 4'h0) begin errors++; $display("FAIL same_cleared: got %h expected 0", resp_valid_out); end
    tick;
    req_valid_in = '0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick;
      #1;
      ev = (k == 5) ? 4'b1000 : 4'h0;
      checks++; if (resp_valid_out !== ev) begin errors++; $display("FAIL same_second_latency t+%0d: got %h expected %h", k, resp_valid_out, ev); end
    end
    got  = resp_data_out[127:96];
    diff = $signed(got) - $signed(32'h0000_4000);
    checks++; if (diff > 4 || diff < -4) begin errors++; $display("FAIL same_second_data: got %h expected 00004000", got); end
  endtask

  initial begin
    rst_n_in      = 1'b0;
    req_valid_in  = '0;
    req_data_in   = '0;
    resp_ready_in = '0;
    test_reset;
    test_single(0, 32'h0000_8000, 32'h0000_8000, 1'b1);
    test_single(2, 32'h0002_0000, 32'h0000_4000, 1'b1);
    test_single(1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    test_all4;
    test_backpressure;
    test_reset_mid;
    test_same_cycle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
